// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 memory stage with multi-cycle byte-addressed data memory
// Optional feature macro: MEM_ALIGN_CHECK_EN (flags any access with addr[2:0] != 0 as an address error)
module memory_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        out_valid,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    icode_q, icode_d;
  logic [63:0]   vale_q, vale_d;
  logic [63:0]   vala_q, vala_d;
  logic [63:0]   valp_q, valp_d;
  logic [63:0]   valm_q, valm_d;
  logic          dmem_error_q, dmem_error_d;
  logic [2:0]    stat_q, stat_d;

  logic [7:0]    mem [MEM_BYTES];

  logic          is_read, is_write, use_vala_addr, mem_acc, addr_err, commit;
  logic [63:0]   addr, wdata, rdata;
  logic [AW-1:0] mem_idx;

  // Decode the latched instruction into address, write data and range/alignment error
  always_comb begin
    is_read       = 1'b0;
    is_write      = 1'b0;
    use_vala_addr = 1'b0;
    wdata         = vala_q;
    case (icode_q)
      I_RMMOVQ: is_write = 1'b1;
      I_PUSHQ:  is_write = 1'b1;
      I_CALL: begin
        is_write = 1'b1;
        wdata    = valp_q;
      end
      I_MRMOVQ: is_read = 1'b1;
      I_RET, I_POPQ: begin
        is_read       = 1'b1;
        use_vala_addr = 1'b1;
      end
      default: ;
    endcase
    addr     = use_vala_addr ? vala_q : vale_q;
    mem_acc  = is_read | is_write;
`ifdef MEM_ALIGN_CHECK_EN
    addr_err = mem_acc && ((addr > MAX_ADDR) || (addr[2:0] != 3'd0));
`else
    addr_err = mem_acc && (addr > MAX_ADDR);
`endif
    mem_idx  = addr[AW-1:0];
    commit   = (state_q == ST_ACCESS) && (cnt_q == '0);
  end

  // Little-endian 8-byte read; only meaningful when the address is in range
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[mem_idx + AW'(i)];
    end
  end

  // Data memory write on the edge leaving ACCESS; contents survive reset
  always_ff @(posedge clk) begin
    if (commit && is_write && !addr_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[mem_idx + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

  // Next-state, input latch, latency counter and result registers
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    icode_d      = icode_q;
    vale_d       = vale_q;
    vala_d       = vala_q;
    valp_d       = valp_q;
    valm_d       = valm_q;
    dmem_error_d = dmem_error_q;
    stat_d       = stat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          icode_d = icode;
          vale_d  = valE;
          vala_d  = valA;
          valp_d  = valP;
          case (icode)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: cnt_d = LAT_M1;
            default: cnt_d = '0;
          endcase
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          valm_d       = (is_read && !addr_err) ? rdata : 64'd0;
          dmem_error_d = addr_err;
          if (icode_q > I_POPQ)       stat_d = S_INS;
          else if (addr_err)          stat_d = S_ADR;
          else if (icode_q == I_HALT) stat_d = S_HLT;
          else                        stat_d = S_AOK;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      icode_q      <= 4'd0;
      vale_q       <= 64'd0;
      vala_q       <= 64'd0;
      valp_q       <= 64'd0;
      valm_q       <= 64'd0;
      dmem_error_q <= 1'b0;
      stat_q       <= S_AOK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      icode_q      <= icode_d;
      vale_q       <= vale_d;
      vala_q       <= vala_d;
      valp_q       <= valp_d;
      valm_q       <= valm_d;
      dmem_error_q <= dmem_error_d;
      stat_q       <= stat_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign valM       = valm_q;
  assign dmem_error = dmem_error_q;
  assign stat       = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed scoreboard bench for memory_stage
module tb_memory_stage;

  localparam int MEM_BYTES = 1024;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        out_valid;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    logic [2:0]  stat;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  memory_stage #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .valE(valE), .valA(valA), .valP(valP),
    .out_valid(out_valid), .valM(valM), .dmem_error(dmem_error), .stat(stat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] ic);
    return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
  endfunction

  // Drive one instruction, push its expectation, then wait for and check the result
  task automatic issue(input string tag, input logic [3:0] ic,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                       input logic [63:0] xm, input logic xe, input logic [2:0] xs);
    exp_t x;
    exp_t got;
    int   lat;
    bit   seen;
    x.valm = xm;
    x.err  = xe;
    x.stat = xs;
    x.lat  = is_mem(ic) ? LATENCY + 1 : 2;
    sb.push_back(x);
    @(negedge clk);
    icode = ic; valE = e; valA = a; valP = p; in_valid = 1'b1;
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Scramble inputs while busy; the stage must ignore them
    icode = 4'hE; valE = {$urandom, $urandom}; valA = {$urandom, $urandom}; valP = {$urandom, $urandom};
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    got = sb.pop_front();
    if (!seen) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_valM"}, valM, got.valm);
      chk({tag, "_err"}, 64'(dmem_error), 64'(got.err));
      chk({tag, "_stat"}, 64'(stat), 64'(got.stat));
      chk({tag, "_lat"}, 64'(lat), 64'(got.lat));
      chk({tag, "_done_rdy"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
      chk({tag, "_hold"}, valM, got.valm);
    end
  endtask

  initial begin
    logic [63:0] v;
    rst_n = 1'b0; in_valid = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_err", 64'(dmem_error), 64'd0);
    chk("rst_stat", 64'(stat), 64'd1);
    rst_n = 1'b1;

    issue("wr18", 4'h4, 64'h18, 64'h0, 64'h0, 64'h0, 1'b0, 3'd1);
    issue("wr10", 4'h4, 64'h10, 64'h1122334455667788, 64'h0, 64'h0, 1'b0, 3'd1);
    issue("rd10", 4'h5, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 1'b0, 3'd1);
`ifdef MEM_ALIGN_CHECK_EN
    issue("rd11", 4'h5, 64'h11, 64'h0, 64'h0, 64'h0, 1'b1, 3'd3);
`else
    issue("rd11", 4'h5, 64'h11, 64'h0, 64'h0, 64'h0011223344556677, 1'b0, 3'd1);
`endif

    issue("call", 4'h8, 64'h100, 64'h0, 64'h2A, 64'h0, 1'b0, 3'd1);
    issue("ret", 4'h9, 64'h0, 64'h100, 64'h0, 64'h2A, 1'b0, 3'd1);

    issue("rd3f9", 4'h5, 64'h3F9, 64'h0, 64'h0, 64'h0, 1'b1, 3'd3);
    issue("wr3f8", 4'hA, 64'h3F8, 64'hA5A55A5A0F0FF0F0, 64'h0, 64'h0, 1'b0, 3'd1);
    issue("rd3f8", 4'hB, 64'h0, 64'h3F8, 64'h0, 64'hA5A55A5A0F0FF0F0, 1'b0, 3'd1);
    issue("rdhuge", 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 64'h0, 1'b1, 3'd3);

    issue("halt", 4'h0, 64'h10, 64'h77, 64'h0, 64'h0, 1'b0, 3'd2);
    issue("ins", 4'hE, 64'h10, 64'h99, 64'h0, 64'h0, 1'b0, 3'd4);
    issue("rd10b", 4'h5, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 1'b0, 3'd1);
    issue("opq", 4'h6, 64'h10, 64'h5, 64'h0, 64'h0, 1'b0, 3'd1);

    // Reset during ACCESS of a write must drop the write
    issue("wr20", 4'h4, 64'h20, 64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b0, 3'd1);
    issue("rd20", 4'h5, 64'h20, 64'h0, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3'd1);
    @(negedge clk);
    icode = 4'h4; valE = 64'h20; valA = 64'hDEAD; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_valM", valM, 64'd0);
    chk("abort_err", 64'(dmem_error), 64'd0);
    chk("abort_stat", 64'(stat), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("rd20_after", 4'h5, 64'h20, 64'h0, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3'd1);

    // Unaligned write to 0x13
    v = 64'hCAFEBABE12345678;
`ifdef MEM_ALIGN_CHECK_EN
    issue("wr13", 4'h4, 64'h13, v, 64'h0, 64'h0, 1'b1, 3'd3);
    issue("rd10c", 4'h5, 64'h10, 64'h0, 64'h0, 64'h1122334455667788, 1'b0, 3'd1);
    issue("rd18", 4'h5, 64'h18, 64'h0, 64'h0, 64'h0, 1'b0, 3'd1);
`else
    issue("wr13", 4'h4, 64'h13, v, 64'h0, 64'h0, 1'b0, 3'd1);
    issue("rd10c", 4'h5, 64'h10, 64'h0, 64'h0, {v[39:0], 24'h667788}, 1'b0, 3'd1);
    issue("rd18", 4'h5, 64'h18, 64'h0, 64'h0, {40'h0, v[63:40]}, 1'b0, 3'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
